// File: rtl/gpu_pkg.sv
// Shared vga_gpu definitions: instruction width, class bit,
// display geometry defaults, scheduler FSM encoding, window decode.
package gpu_pkg;

  localparam int INSTR_W       = 32;
  localparam int CLASS_BIT     = 31;
  localparam int PIX_W         = 10;
  localparam int H_VISIBLE_DEF = 640;
  localparam int V_VISIBLE_DEF = 480;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ISSUE,
    S_GAP
  } sched_state_e;

  // FRAME class needs vblank; LINE class takes either blank.
  function automatic logic window_open(
    input logic             frame,
    input logic [PIX_W-1:0] x,
    input logic [PIX_W-1:0] y,
    input logic [PIX_W-1:0] hv,
    input logic [PIX_W-1:0] vv
  );
    logic hb;
    logic vb;
    hb = (x >= hv);
    vb = (y >= vv);
    return frame ? vb : (hb | vb);
  endfunction

endpackage

// File: rtl/instruction_fifo.sv
// DEPTH x INSTR_W queue with push/pop/flush; head is read
// combinationally. Ports: push/data in, pop, flush, head, empty/full, busy (registered), count.
module instruction_fifo
  import gpu_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               push_i,
  input  logic [INSTR_W-1:0] data_i,
  input  logic               pop_i,
  input  logic               flush_i,
  output logic [INSTR_W-1:0] head_o,
  output logic               empty_o,
  output logic               full_o,
  output logic               busy_o,
  output logic [CW-1:0]      count_o
);

  logic [INSTR_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]      wr_q, wr_d;
  logic [AW-1:0]      rd_q, rd_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               busy_q;
  logic               do_push;
  logic               do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign head_o  = mem_q[rd_q];
  assign busy_o  = busy_q;
  assign count_o = cnt_q;

  // A pop frees a slot before the push lands.
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign do_push = push_i && !flush_i && (!full_o || do_pop);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + AW'(1);
      if (do_pop)  rd_d = rd_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      busy_q <= (cnt_d == CW'(DEPTH));
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/instruction_scheduler.sv
// Queues decoded instructions and issues them in order inside blanking windows,
// spaced by a gap. Ports: decoder push/busy, flush, beam x/y, issue strobe/data, level, overflow.
module instruction_scheduler
  import gpu_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int ISSUE_GAP = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [INSTR_W-1:0] i_instruction,
  input  logic               i_instruction_ready,
  output logic               o_busy,
  input  logic               i_flush,
  input  logic [PIX_W-1:0]   i_pixel_x,
  input  logic [PIX_W-1:0]   i_pixel_y,
  output logic [INSTR_W-1:0] o_instruction,
  output logic               o_instruction_ready,
  output logic [3:0]         o_level,
  output logic               o_overflow
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int GW = $clog2(ISSUE_GAP + 1);

  sched_state_e       state_q, state_d;
  logic [GW-1:0]      gap_q, gap_d;
  logic [INSTR_W-1:0] instr_q;
  logic               stb_q;
  logic               ovf_q;
  logic               pop;
  logic               win;
  logic [INSTR_W-1:0] head;
  logic               empty;
  logic               full;
  logic [CW-1:0]      count;

  instruction_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i   (i_clk),
    .rst_n_i (i_rst_n),
    .push_i  (i_instruction_ready),
    .data_i  (i_instruction),
    .pop_i   (pop),
    .flush_i (i_flush),
    .head_o  (head),
    .empty_o (empty),
    .full_o  (full),
    .busy_o  (o_busy),
    .count_o (count)
  );

  assign win = window_open(head[CLASS_BIT], i_pixel_x, i_pixel_y,
                           PIX_W'(H_VISIBLE), PIX_W'(V_VISIBLE));

  // Pop happens on the WAIT->ISSUE edge, so the strobe and
  // the lower level appear together during ISSUE.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!i_flush && !empty) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (i_flush || empty) begin
          state_d = S_IDLE;
        end else if (win) begin
          state_d = S_ISSUE;
          pop     = 1'b1;
        end
      end
      S_ISSUE: begin
        state_d = S_GAP;
        gap_d   = GW'(ISSUE_GAP - 1);
      end
      S_GAP: begin
        if (i_flush) begin
          state_d = S_IDLE;
          gap_d   = '0;
        end else if (gap_q <= GW'(1)) begin
          gap_d   = '0;
          state_d = empty ? S_IDLE : S_WAIT;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      gap_q   <= '0;
      instr_q <= '0;
      stb_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      stb_q   <= pop;
      if (pop) instr_q <= head;
      if (i_instruction_ready && full && !pop && !i_flush)
        ovf_q <= 1'b1;
    end
  end

  assign o_instruction       = instr_q;
  assign o_instruction_ready = stb_q;
  assign o_level             = 4'(count);
  assign o_overflow          = ovf_q;

endmodule

// File: tb/tb_instruction_scheduler.sv
// Directed bench for instruction_scheduler: reset, windows,
// ordering, full/overflow, push-on-pop, flush-in-issue, mid-issue reset.
module tb_instruction_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        ready;
  logic        busy;
  logic        flush;
  logic [9:0]  px;
  logic [9:0]  py;
  logic [31:0] o_instr;
  logic        o_stb;
  logic [3:0]  level;
  logic        ovf;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  instruction_scheduler dut (
    .i_clk               (clk),
    .i_rst_n             (rst_n),
    .i_instruction       (instr),
    .i_instruction_ready (ready),
    .o_busy              (busy),
    .i_flush             (flush),
    .i_pixel_x           (px),
    .i_pixel_y           (py),
    .o_instruction       (o_instr),
    .o_instruction_ready (o_stb),
    .o_level             (level),
    .o_overflow          (ovf)
  );

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wait_strobe(input int max, output int n, output bit ok);
    ok = 1'b0;
    n  = 0;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (o_stb === 1'b1) begin
        n  = i;
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic push(input logic [31:0] v);
    instr = v;
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ready = 1'b0;
    flush = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    px = '0;
    py = '0;
    for (int i = 0; i < 3; i++) begin
      instr = 32'hDEAD_0000 + 32'(i);
      ready = 1'b1;
      @(negedge clk);
    end
    checks++;
    if ({o_stb, busy, ovf, level, o_instr} !== 39'd0) begin
      errors++;
      $display("FAIL reset_outputs got stb=%b busy=%b ovf=%b lvl=%0d ins=%h want all 0",
               o_stb, busy, ovf, level, o_instr);
    end
    ready = 1'b0;
    rst_n = 1'b1;
    cycles(2);
    checks++;
    if (level !== 4'd0 || o_stb !== 1'b0) begin
      errors++;
      $display("FAIL reset_push_ignored got lvl=%0d stb=%b want 0 0", level, o_stb);
    end
  endtask

  task automatic test_line_window();
    int n;
    bit ok;
    bit seen;
    px = 10'd100;
    py = 10'd10;
    push(32'h0000_00AA);
    checks++;
    if (level !== 4'd1) begin
      errors++;
      $display("FAIL line_level got %0d want 1", level);
    end
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (o_stb !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL line_early got strobe want none");
    end
    px = 10'd640;
    wait_strobe(10, n, ok);
    checks++;
    if (!ok || n != 1) begin
      errors++;
      $display("FAIL line_issue got ok=%0d n=%0d want 1 1", ok, n);
    end
    checks++;
    if (o_instr !== 32'h0000_00AA || level !== 4'd0) begin
      errors++;
      $display("FAIL line_data got ins=%h lvl=%0d want 000000aa 0", o_instr, level);
    end
    @(negedge clk);
    checks++;
    if (o_stb !== 1'b0 || o_instr !== 32'h0000_00AA) begin
      errors++;
      $display("FAIL line_one_cycle got stb=%b ins=%h want 0 000000aa", o_stb, o_instr);
    end
    px = '0;
    py = '0;
    cycles(8);
  endtask

  task automatic test_frame_order();
    int n;
    bit ok;
    bit seen;
    int lines[4] = '{10, 11, 200, 479};
    int first;
    px = '0;
    py = 10'd10;
    push(32'h8000_0001);
    push(32'h0000_0002);
    foreach (lines[j]) begin
      seen = 1'b0;
      py = 10'(lines[j]);
      px = 10'd640;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (o_stb !== 1'b0) seen = 1'b1;
      end
      px = '0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        if (o_stb !== 1'b0) seen = 1'b1;
      end
      checks++;
      if (seen) begin
        errors++;
        $display("FAIL frame_hblank y=%0d got strobe want none", lines[j]);
      end
    end
    py = 10'd480;
    wait_strobe(10, n, ok);
    checks++;
    if (!ok || n != 1 || o_instr !== 32'h8000_0001) begin
      errors++;
      $display("FAIL frame_issue got ok=%0d n=%0d ins=%h want 1 1 80000001", ok, n, o_instr);
    end
    first = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (o_stb === 1'b1 && first == 0) begin
        first = k;
        checks++;
        if (o_instr !== 32'h0000_0002) begin
          errors++;
          $display("FAIL frame_second_data got %h want 00000002", o_instr);
        end
      end
    end
    checks++;
    if (first != 5) begin
      errors++;
      $display("FAIL frame_gap got %0d want 5", first);
    end
    py = '0;
    cycles(8);
  endtask

  task automatic test_full_overflow();
    int n;
    bit ok;
    px = '0;
    py = '0;
    for (int i = 0; i < 9; i++) begin
      instr = 32'h100 + 32'(i);
      ready = 1'b1;
      @(negedge clk);
      if (i == 7) begin
        checks++;
        if (busy !== 1'b1 || level !== 4'd8 || ovf !== 1'b0) begin
          errors++;
          $display("FAIL full_busy got busy=%b lvl=%0d ovf=%b want 1 8 0", busy, level, ovf);
        end
      end
    end
    ready = 1'b0;
    checks++;
    if (level !== 4'd8 || ovf !== 1'b1) begin
      errors++;
      $display("FAIL full_drop got lvl=%0d ovf=%b want 8 1", level, ovf);
    end
    px = 10'd640;
    for (int k = 0; k < 8; k++) begin
      wait_strobe(12, n, ok);
      checks++;
      if (!ok || o_instr !== 32'h100 + 32'(k)) begin
        errors++;
        $display("FAIL full_order k=%0d got ok=%0d ins=%h want %h", k, ok, o_instr, 32'h100 + k);
      end
      if (k == 0) begin
        checks++;
        if (busy !== 1'b0 || level !== 4'd7) begin
          errors++;
          $display("FAIL full_busy_fall got busy=%b lvl=%0d want 0 7", busy, level);
        end
      end
    end
    cycles(6);
    checks++;
    if (level !== 4'd0 || ovf !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL full_drain got lvl=%0d ovf=%b busy=%b want 0 1 0", level, ovf, busy);
    end
    px = '0;
  endtask

  task automatic test_push_on_pop();
    int n;
    bit ok;
    do_reset();
    px = '0;
    py = '0;
    for (int i = 0; i < 8; i++) push(32'h200 + 32'(i));
    @(negedge clk);
    px    = 10'd640;
    instr = 32'h2FF;
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    checks++;
    if (o_stb !== 1'b1 || o_instr !== 32'h200 || level !== 4'd8 || ovf !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL pushpop got stb=%b ins=%h lvl=%0d ovf=%b busy=%b want 1 200 8 0 1",
               o_stb, o_instr, level, ovf, busy);
    end
    for (int k = 1; k <= 8; k++) begin
      wait_strobe(12, n, ok);
      checks++;
      if (!ok || o_instr !== ((k < 8) ? 32'h200 + 32'(k) : 32'h2FF)) begin
        errors++;
        $display("FAIL pushpop_order k=%0d got ok=%0d ins=%h", k, ok, o_instr);
      end
    end
    px = '0;
    cycles(8);
  endtask

  task automatic test_flush_in_issue();
    int n;
    bit ok;
    bit seen;
    px = '0;
    py = '0;
    push(32'h300);
    push(32'h301);
    push(32'h302);
    cycles(2);
    px = 10'd640;
    @(negedge clk);
    checks++;
    if (o_stb !== 1'b1 || o_instr !== 32'h300 || level !== 4'd2) begin
      errors++;
      $display("FAIL flush_issue got stb=%b ins=%h lvl=%0d want 1 300 2", o_stb, o_instr, level);
    end
    flush = 1'b1;
    instr = 32'h3AA;
    ready = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    ready = 1'b0;
    checks++;
    if (o_stb !== 1'b0 || level !== 4'd0) begin
      errors++;
      $display("FAIL flush_clear got stb=%b lvl=%0d want 0 0", o_stb, level);
    end
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (o_stb !== 1'b0 || level !== 4'd0) seen = 1'b1;
    end
    checks++;
    if (seen || o_instr !== 32'h300) begin
      errors++;
      $display("FAIL flush_quiet got extra activity ins=%h want none 300", o_instr);
    end
    push(32'h3BB);
    wait_strobe(10, n, ok);
    checks++;
    if (!ok || n != 2 || o_instr !== 32'h3BB) begin
      errors++;
      $display("FAIL flush_idle_latency got ok=%0d n=%0d ins=%h want 1 2 3bb", ok, n, o_instr);
    end
    cycles(8);
  endtask

  task automatic test_reset_mid_issue();
    int n;
    bit ok;
    px = 10'd640;
    push(32'h4CC);
    push(32'h4DD);
    wait_strobe(10, n, ok);
    checks++;
    if (!ok || o_instr !== 32'h4CC) begin
      errors++;
      $display("FAIL midrst_issue got ok=%0d ins=%h want 1 4cc", ok, o_instr);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (o_stb !== 1'b0 || o_instr !== 32'h0 || level !== 4'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_async got stb=%b ins=%h lvl=%0d busy=%b want 0 0 0 0",
               o_stb, o_instr, level, busy);
    end
    cycles(2);
    rst_n = 1'b1;
    cycles(12);
    checks++;
    if (o_instr !== 32'h0 || level !== 4'd0) begin
      errors++;
      $display("FAIL midrst_lost got ins=%h lvl=%0d want 0 0", o_instr, level);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    instr = '0;
    ready = 1'b0;
    flush = 1'b0;
    px    = '0;
    py    = '0;
    @(negedge clk);
    test_reset();
    test_line_window();
    test_frame_order();
    test_full_overflow();
    test_push_on_pop();
    test_flush_in_issue();
    test_reset_mid_issue();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
